// File: rtl/id_ex_reg_if.sv
// Bundle of ID-to-EX pipeline register signals: control/hazard inputs,
// decoded instruction fields from ID and their registered EX-stage copies.
interface id_ex_reg_if #(
  parameter int XLEN  = 32,
  parameter int RADDR = 5
);
  logic             stall_i;
  logic             flush_i;
  logic             valid_i;
  logic [6:0]       ctrl_i;
  logic [XLEN-1:0]  rs1_data_i;
  logic [XLEN-1:0]  rs2_data_i;
  logic [XLEN-1:0]  imm_i;
  logic [9:0]       funct_i;
  logic [RADDR-1:0] rs1_addr_i;
  logic [RADDR-1:0] rs2_addr_i;
  logic [RADDR-1:0] rd_addr_i;

  logic             valid_o;
  logic [6:0]       ctrl_o;
  logic [XLEN-1:0]  rs1_data_o;
  logic [XLEN-1:0]  rs2_data_o;
  logic [XLEN-1:0]  imm_o;
  logic [9:0]       funct_o;
  logic [RADDR-1:0] rs1_addr_o;
  logic [RADDR-1:0] rs2_addr_o;
  logic [RADDR-1:0] rd_addr_o;
  logic [15:0]      bubble_cnt_o;

  // ID stage / hazard unit side: drives the *_i fields, observes the *_o copies
  modport master (
    output stall_i, flush_i, valid_i, ctrl_i, rs1_data_i, rs2_data_i, imm_i,
           funct_i, rs1_addr_i, rs2_addr_i, rd_addr_i,
    input  valid_o, ctrl_o, rs1_data_o, rs2_data_o, imm_o, funct_o,
           rs1_addr_o, rs2_addr_o, rd_addr_o, bubble_cnt_o
  );

  // Pipeline register side: samples the *_i fields, drives the *_o copies
  modport slave (
    input  stall_i, flush_i, valid_i, ctrl_i, rs1_data_i, rs2_data_i, imm_i,
           funct_i, rs1_addr_i, rs2_addr_i, rd_addr_i,
    output valid_o, ctrl_o, rs1_data_o, rs2_data_o, imm_o, funct_o,
           rs1_addr_o, rs2_addr_o, rd_addr_o, bubble_cnt_o
  );
endinterface

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register. Captures decoded instruction fields each cycle,
// holds on stall, inserts an all-zero bubble on flush and counts bubbles
// with a saturating 16-bit counter. Every output comes straight from a flop.
module id_ex_reg #(
  parameter int XLEN  = 32,
  parameter int RADDR = 5
) (
  input  logic       clk_i,
  input  logic       rst_i,
  id_ex_reg_if.slave bus
);

  // RegWrite is the MSB of the control vector {RegWrite, MemtoReg, MemRead,
  // MemWrite, ALUOp[1:0], ALUSrc}.
  localparam int REG_WRITE_BIT = 6;

  logic             valid_d;
  logic [6:0]       ctrl_d;
  logic [XLEN-1:0]  rs1_data_d;
  logic [XLEN-1:0]  rs2_data_d;
  logic [XLEN-1:0]  imm_d;
  logic [9:0]       funct_d;
  logic [RADDR-1:0] rs1_addr_d;
  logic [RADDR-1:0] rs2_addr_d;
  logic [RADDR-1:0] rd_addr_d;
  logic [15:0]      bubble_cnt_d;

  // Next-state selection: flush beats stall beats load; holding is the default
  always_comb begin
    valid_d      = bus.valid_o;
    ctrl_d       = bus.ctrl_o;
    rs1_data_d   = bus.rs1_data_o;
    rs2_data_d   = bus.rs2_data_o;
    imm_d        = bus.imm_o;
    funct_d      = bus.funct_o;
    rs1_addr_d   = bus.rs1_addr_o;
    rs2_addr_d   = bus.rs2_addr_o;
    rd_addr_d    = bus.rd_addr_o;
    bubble_cnt_d = bus.bubble_cnt_o;

    if (bus.flush_i) begin
      // Bubble fields are constants, so garbage on the data inputs cannot leak
      valid_d    = 1'b0;
      ctrl_d     = '0;
      rs1_data_d = '0;
      rs2_data_d = '0;
      imm_d      = '0;
      funct_d    = '0;
      rs1_addr_d = '0;
      rs2_addr_d = '0;
      rd_addr_d  = '0;
      if (bus.bubble_cnt_o != 16'hFFFF) begin
        bubble_cnt_d = bus.bubble_cnt_o + 16'd1;
      end
    end else if (!bus.stall_i) begin
      valid_d    = bus.valid_i;
      rs1_data_d = bus.rs1_data_i;
      rs2_data_d = bus.rs2_data_i;
      imm_d      = bus.imm_i;
      funct_d    = bus.funct_i;
      rs1_addr_d = bus.rs1_addr_i;
      rs2_addr_d = bus.rs2_addr_i;
      if (bus.valid_i) begin
        ctrl_d    = bus.ctrl_i;
        rd_addr_d = bus.rd_addr_i;
        // A write to x0 is architecturally a no-op; drop it so EX/WB never
        // see RegWrite with a zero destination.
        if (bus.rd_addr_i == '0) begin
          ctrl_d[REG_WRITE_BIT] = 1'b0;
        end
      end else begin
        ctrl_d    = '0;
        rd_addr_d = '0;
      end
    end
  end

  // State register with synchronous reset that overrides flush and stall
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bus.valid_o      <= 1'b0;
      bus.ctrl_o       <= '0;
      bus.rs1_data_o   <= '0;
      bus.rs2_data_o   <= '0;
      bus.imm_o        <= '0;
      bus.funct_o      <= '0;
      bus.rs1_addr_o   <= '0;
      bus.rs2_addr_o   <= '0;
      bus.rd_addr_o    <= '0;
      bus.bubble_cnt_o <= '0;
    end else begin
      bus.valid_o      <= valid_d;
      bus.ctrl_o       <= ctrl_d;
      bus.rs1_data_o   <= rs1_data_d;
      bus.rs2_data_o   <= rs2_data_d;
      bus.imm_o        <= imm_d;
      bus.funct_o      <= funct_d;
      bus.rs1_addr_o   <= rs1_addr_d;
      bus.rs2_addr_o   <= rs2_addr_d;
      bus.rd_addr_o    <= rd_addr_d;
      bus.bubble_cnt_o <= bubble_cnt_d;
    end
  end

endmodule
